kalman_matmul_seq: RTL



---
 rtl/kalman_matmul_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/kalman_matmul_seq.sv
// Sequential P x P signed fixed-point matrix multiplier, C = A*B or C = A*B^T.
// P*P MAC lanes walk the inner dimension one term per clock, then round and saturate into C.
module kalman_matmul_seq #(
    parameter int N = 32,
    parameter int Q = 18,
    parameter int P = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             trans_b,
    input  logic [P*P*N-1:0] A,
    input  logic [P*P*N-1:0] B,
    output logic [P*P*N-1:0] C,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int KW = $clog2(P);
    localparam int AW = 2*N + KW;
    localparam int E  = P*P;

    localparam logic [KW-1:0]    K_LAST = KW'(P-1);
    localparam logic signed [AW:0] RND  = {{(AW+1-Q){1'b0}}, 1'b1, {(Q-1){1'b0}}};
    localparam logic signed [AW:0] SMAX = {{(AW+2-N){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [AW:0] SMIN = {{(AW+2-N){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, NORM} state_t;

    state_t state, state_next;

    logic [P*P*N-1:0]      a_reg, b_reg;
    logic                  trans_reg;
    logic [KW-1:0]         k;
    logic signed [AW-1:0]  acc [E];
    logic signed [2*N-1:0] prod [E];
    logic [P*P*N-1:0]      c_next;
    logic [E-1:0]          sat;

    for (genvar r = 0; r < P; r++) begin : g_row
        for (genvar c = 0; c < P; c++) begin : g_col
            localparam int I = r*P + c;
            logic signed [N-1:0]   a_el, b_el;
            logic signed [2*N-1:0] a_x, b_x;
            logic signed [AW:0]    acc_x, rnd;
            logic                  hi, lo;

            assign a_el = a_reg[(r*P + int'(k))*N +: N];
            assign b_el = trans_reg ? b_reg[(c*P + int'(k))*N +: N]
                                    : b_reg[(int'(k)*P + c)*N +: N];
            assign a_x  = {{N{a_el[N-1]}}, a_el};
            assign b_x  = {{N{b_el[N-1]}}, b_el};
            assign prod[I] = a_x * b_x;

            // round half toward +inf, then saturate on the full-width shifted value
            assign acc_x = {acc[I][AW-1], acc[I]};
            assign rnd   = (acc_x + RND) >>> Q;
            assign hi    = rnd > SMAX;
            assign lo    = rnd < SMIN;
            assign sat[I] = hi | lo;
            assign c_next[I*N +: N] = hi ? {1'b0, {(N-1){1'b1}}} :
                                      lo ? {1'b1, {(N-1){1'b0}}} : rnd[N-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (k == K_LAST) state_next = NORM;
            NORM:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            trans_reg <= 1'b0;
            k         <= '0;
            C         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            for (int i = 0; i < E; i++) acc[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        trans_reg <= trans_b;
                        k         <= '0;
                        busy      <= 1'b1;
                        for (int i = 0; i < E; i++) acc[i] <= '0;
                    end
                end
                ACCUM: begin
                    for (int i = 0; i < E; i++)
                        acc[i] <= acc[i] + {{(AW-2*N){prod[i][2*N-1]}}, prod[i]};
                    k <= k + 1'b1;
                end
                NORM: begin
                    C        <= c_next;
                    overflow <= |sat;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
